branch_predictor: RTL and testbench



---
 rtl/core_pkg.sv | 22 ++
 rtl/bht_sat_ctr.sv | 25 ++
 rtl/branch_predictor.sv | 108 ++++++++++
 tb/tb_branch_predictor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: branch-history counter states and the EX-stage
// branch-control encodings seen by the predictor's update path.
package core_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] RESET_BHT_STATE = WNT;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    JUMP = 3'b011,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } b_control_e;

endpackage

// File: rtl/bht_sat_ctr.sv
// Next state of a 2-bit branch history counter for one resolved branch/jump.
module bht_sat_ctr
  import core_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       is_jump,
  input  logic       alloc,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (is_jump) begin
      nxt = ST;
    end else if (taken) begin
      // A freshly allocated entry starts weakly taken, ignoring the stale counter.
      if (alloc)          nxt = WT;
      else if (cur != ST) nxt = cur + 2'd1;
    end else if (cur != SNT) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: flop-based BHT + tagged BTB, trained
// from EX, with a registered one-cycle redirect on mispredict and statistics.
module branch_predictor
  import core_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic [1:0]       ctr_nxt;
  logic             tbl_we, entry_we, mp;
  logic             unused_lsbs;

  assign unused_lsbs = ^{pc_f[1:0], upd_pc[1:0]};

  // Fetch lookup: reads the table as it stood before this cycle's update.
  assign f_idx       = pc_f[IDX_W+1:2];
  assign f_tag       = pc_f[31:IDX_W+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : pc_f + 32'd4;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  bht_sat_ctr u_ctr (
    .cur     (ctr_q[u_idx]),
    .taken   (upd_taken),
    .is_jump (upd_is_jump),
    .alloc   (!u_hit),
    .nxt     (ctr_nxt)
  );

  // Not-taken branches that miss leave the table alone; taken ones (re)allocate.
  assign entry_we = upd_valid && (upd_is_jump || upd_taken);
  assign tbl_we   = entry_we || (upd_valid && u_hit);

  assign mp = upd_valid &&
              ((upd_taken != upd_pred_taken) ||
               (upd_taken && (upd_pred_target != upd_target)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= RESET_BHT_STATE;
      end
    end else begin
      if (tbl_we) ctr_q[u_idx] <= ctr_nxt;
      if (entry_we) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_target;
      end
    end
  end

  // Update -> redirect/statistics register boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      redirect_valid <= mp;
      if (mp) begin
        redirect_pc   <= upd_taken ? upd_target : upd_pc + 32'd4;
        mispred_count <= sat_inc(mispred_count);
      end
      if (upd_valid) br_count <= sat_inc(br_count);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + randomized bench for branch_predictor against a table-level
// reference model (integer counters, plain arrays).
module tb_branch_predictor;

  localparam int ENT = 64;
  localparam int IW  = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.ENTRIES(ENT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_f            (pc_f),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  bit          m_v   [ENT];
  longint      m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  int          m_ctr [ENT];
  logic        m_rv;
  logic [31:0] m_rpc;
  longint      m_br, m_mp;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic longint mtag(input logic [31:0] pc);
    return longint'(pc >> (IW + 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_rv = 0; m_rpc = 0; m_br = 0; m_mp = 0;
  endtask

  function automatic void mlook(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    bit hit;
    i   = midx(pc);
    hit = m_v[i] && (m_tag[i] == mtag(pc));
    t   = hit && (m_ctr[i] >= 2);
    tg  = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic model_update(input logic [31:0] upc, input logic uj, input logic ut,
                              input logic [31:0] utg);
    int  i;
    bit  hit;
    i   = midx(upc);
    hit = m_v[i] && (m_tag[i] == mtag(upc));
    if (uj) begin
      m_v[i] = 1; m_tag[i] = mtag(upc); m_tgt[i] = utg; m_ctr[i] = 3;
    end else if (ut) begin
      if (hit) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = utg;
      end else begin
        m_v[i] = 1; m_tag[i] = mtag(upc); m_tgt[i] = utg; m_ctr[i] = 2;
      end
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
  endtask

  // One cycle: drive at negedge, check lookup, clock, check registered outputs.
  task automatic step(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                      input logic uj, input logic ut, input logic [31:0] utg,
                      input logic upt, input logic [31:0] uptg);
    logic        et;
    logic [31:0] etg;
    logic        mp;
    pc_f = pc; upd_valid = uv; upd_pc = upc; upd_is_jump = uj; upd_taken = ut;
    upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
    #1;
    mlook(pc, et, etg);
    check("pred_taken", {31'd0, pred_taken}, {31'd0, et});
    check("pred_target", pred_target, etg);
    mp = uv && ((ut != upt) || (ut && (uptg != utg)));
    @(posedge clk);
    #1;
    if (uv) model_update(upc, uj, ut, utg);
    m_rv = mp;
    if (mp) m_rpc = ut ? utg : upc + 32'd4;
    if (uv && m_br < 64'hFFFF_FFFF) m_br++;
    if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    check("redirect_pc", redirect_pc, m_rpc);
    check("br_count", br_count, m_br[31:0]);
    check("mispred_count", mispred_count, m_mp[31:0]);
    @(negedge clk);
  endtask

  // Resolved update whose piped prediction comes from the model, as fetch saw it.
  task automatic br(input logic [31:0] pc, input logic [31:0] upc, input logic uj,
                    input logic ut, input logic [31:0] utg);
    logic        pt;
    logic [31:0] ptg;
    mlook(upc, pt, ptg);
    step(pc, 1'b1, upc, uj, ut, utg, pt, ptg);
  endtask

  task automatic idle(input logic [31:0] pc);
    step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  logic [31:0] pool [6];

  initial begin
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
    pool[3] = 32'h100 + 4 * ENT; pool[4] = 32'h3FC; pool[5] = 32'hFFFF_FFFC;
    model_reset();
    rst_n = 1'b0; pc_f = 32'h100; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and cold lookup
    idle(32'h100);
    // Taken branch, cold -> mispredict, then predicted taken
    br(32'h100, 32'h100, 1'b0, 1'b1, 32'h80);
    idle(32'h100);
    // Training: taken x3, not-taken, taken-still, not-taken -> not predicted
    repeat (3) br(32'h100, 32'h100, 1'b0, 1'b1, 32'h80);
    br(32'h100, 32'h100, 1'b0, 1'b0, 32'h80);
    idle(32'h100);
    br(32'h100, 32'h100, 1'b0, 1'b0, 32'h80);
    idle(32'h100);
    // Aliasing replaces the tag
    br(32'h100, 32'h100 + 4 * ENT, 1'b0, 1'b1, 32'h500);
    idle(32'h100);
    idle(32'h100 + 4 * ENT);
    // Same-cycle update/lookup, then target mismatch with right direction
    br(32'h200, 32'h200, 1'b0, 1'b1, 32'h300);
    idle(32'h200);
    br(32'h200, 32'h200, 1'b0, 1'b1, 32'h340);
    // Jump, not-taken miss, PC wrap
    br(32'h400, 32'h400, 1'b1, 1'b1, 32'h40);
    idle(32'h400);
    br(32'h500, 32'h500, 1'b0, 1'b0, 32'h600);
    idle(32'h500);
    idle(32'hFFFF_FFFC);

    // Asynchronous reset while a redirect is pending
    br(32'h100, 32'h700, 1'b0, 1'b1, 32'h900);
    check("redirect_before_rst", {31'd0, redirect_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_br_count", br_count, 32'd0);
    check("rst_mispred_count", mispred_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(32'h700);
    idle(32'h200);

    // Counter saturation
    force dut.br_count = 32'hFFFF_FFFF;
    force dut.mispred_count = 32'hFFFF_FFFF;
    m_br = 64'hFFFF_FFFF; m_mp = 64'hFFFF_FFFF;
    br(32'h100, 32'h800, 1'b0, 1'b1, 32'hA00);
    release dut.br_count;
    release dut.mispred_count;
    br(32'h100, 32'h900, 1'b1, 1'b1, 32'hB00);
    br(32'h100, 32'h800, 1'b0, 1'b0, 32'hA00);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, upc, utg, ptg;
      logic        uv, uj, ut, pt;
      pc  = ($urandom % 4 != 0) ? pool[$urandom % 6] : ($urandom & 32'hFFFF_FFFC);
      uv  = ($urandom % 4) != 0;
      upc = pool[$urandom % 6];
      uj  = ($urandom % 5) == 0;
      ut  = uj ? 1'b1 : 1'($urandom % 2);
      case ($urandom % 4)
        0: utg = 32'h80;
        1: utg = 32'h300;
        2: utg = 32'h340;
        default: utg = $urandom & 32'hFFFF_FFFC;
      endcase
      mlook(upc, pt, ptg);
      if ($urandom % 3 == 0) begin
        pt  = 1'($urandom % 2);
        ptg = ($urandom % 2 != 0) ? utg : ($urandom & 32'hFFFF_FFFC);
      end
      step(pc, uv, upc, uj, ut, utg, pt, ptg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
